// File: rtl/store_merge_queue_pkg.sv
// Shared types and helpers for the LSU store merge queue.
package store_merge_queue_pkg;

    localparam int unsigned SMQ_PADDR_W = 56;
    localparam int unsigned SMQ_DATA_W  = 64;
    localparam int unsigned SMQ_BE_W    = SMQ_DATA_W / 8;

    // Sized for the widest supported store; narrower configs use the low bits.
    typedef struct packed {
        logic [SMQ_PADDR_W-1:0] paddr;
        logic [SMQ_DATA_W-1:0]  data;
        logic [SMQ_BE_W-1:0]    be;
    } smq_entry_t;

    typedef enum logic [1:0] {
        SMQ_IDLE,
        SMQ_REQ,
        SMQ_WAIT_ACK
    } smq_drain_state_e;

    function automatic logic smq_word_match(input logic [SMQ_PADDR_W-1:0] addr_a,
                                            input logic [SMQ_PADDR_W-1:0] addr_b,
                                            input int unsigned data_w);
        int unsigned off;
        off = (data_w == 32) ? 2 : 3;
        return (addr_a >> off) == (addr_b >> off);
    endfunction

endpackage

// File: rtl/store_merge_queue_fifo.sv
// Circular buffer with a view of every slot and a write port into the youngest entry.
module store_merge_queue_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type entry_t = logic,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = PW + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr,
    input  logic                  push,
    input  entry_t                push_data,
    input  logic                  pop,
    input  logic                  merge,
    input  entry_t                merge_data,
    output logic [CW-1:0]         cnt,
    output logic [PW-1:0]         head_idx,
    output entry_t [DEPTH-1:0]    entries,
    output logic [DEPTH-1:0]      vld
);

    logic [PW-1:0] tail_idx;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr) begin
            head_idx <= '0;
            tail_idx <= '0;
            cnt      <= '0;
        end else begin
            if (push) tail_idx <= tail_idx + PW'(1);
            if (pop)  head_idx <= head_idx + PW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    // Payload is not reset; validity comes from head/count alone.
    always_ff @(posedge clk_i) begin
        if (rst_ni && push && !clr) entries[tail_idx] <= push_data;
        if (rst_ni && merge)        entries[tail_idx - PW'(1)] <= merge_data;
    end

    always_comb begin
        vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            vld[i] = {1'b0, PW'(i) - head_idx} < cnt;
        end
    end

endmodule

// File: rtl/store_merge_queue.sv
// Speculative + committed store queues with commit-time write combining and a dcache drain FSM.
module store_merge_queue
    import store_merge_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned PADDR_W  = 56,
    parameter bit          MERGE_EN = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [PADDR_W-1:0]  paddr_i,
    input  logic [DATA_W-1:0]   data_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic                commit_i,
    output logic                commit_ready_o,
    input  logic [11:0]         page_offset_i,
    output logic                page_offset_matches_o,
    output logic                no_st_pending_o,
    output logic                empty_o,
    output logic                mem_req_o,
    input  logic                mem_gnt_i,
    output logic [PADDR_W-1:0]  mem_addr_o,
    output logic [DATA_W-1:0]   mem_data_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    input  logic                mem_ack_i
);

    localparam int unsigned BE_W = DATA_W / 8;
    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CW   = PW + 1;

    smq_entry_t                in_entry, spec_head, com_head, com_last, merged;
    smq_entry_t [DEPTH-1:0]    spec_entries, com_entries;
    logic [DEPTH-1:0]          spec_vld, com_vld;
    logic [CW-1:0]             spec_cnt, com_cnt;
    logic [PW-1:0]             spec_head_idx, com_head_idx, com_last_idx;
    smq_drain_state_e          state_q, state_d;
    logic                      push, commit, merge_hit, in_flight, head_busy, last_busy, com_pop;
    logic [SMQ_PADDR_W-1:0]    pg;

    assign in_entry = '{paddr: SMQ_PADDR_W'(paddr_i), data: SMQ_DATA_W'(data_i), be: SMQ_BE_W'(be_i)};

    assign ready_o   = spec_cnt < CW'(DEPTH);
    assign push      = valid_i && ready_o && !flush_i;
    assign spec_head = spec_entries[spec_head_idx];

    assign com_head     = com_entries[com_head_idx];
    assign com_last_idx = com_head_idx + PW'(com_cnt - CW'(1));
    assign com_last     = com_entries[com_last_idx];

    // The head counts as busy in its grant cycle too: its data has already left on mem_data_o.
    assign in_flight = state_q == SMQ_WAIT_ACK;
    assign head_busy = in_flight || (state_q == SMQ_REQ && mem_gnt_i);
    assign last_busy = head_busy && com_cnt == CW'(1);
    assign merge_hit = MERGE_EN && com_cnt != '0 && !last_busy &&
                       smq_word_match(spec_head.paddr, com_last.paddr, DATA_W);

    assign commit_ready_o = spec_cnt != '0 && (com_cnt < CW'(DEPTH) || merge_hit);
    assign commit         = commit_i && commit_ready_o;
    assign com_pop        = in_flight && mem_ack_i;

    always_comb begin
        merged    = com_last;
        merged.be = com_last.be | spec_head.be;
        for (int b = 0; b < SMQ_BE_W; b++) begin
            if (spec_head.be[b]) merged.data[8*b +: 8] = spec_head.data[8*b +: 8];
        end
    end

    store_merge_queue_fifo #(.DEPTH(DEPTH), .entry_t(smq_entry_t)) u_spec (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr        (flush_i),
        .push       (push),
        .push_data  (in_entry),
        .pop        (commit),
        .merge      (1'b0),
        .merge_data ('0),
        .cnt        (spec_cnt),
        .head_idx   (spec_head_idx),
        .entries    (spec_entries),
        .vld        (spec_vld)
    );

    store_merge_queue_fifo #(.DEPTH(DEPTH), .entry_t(smq_entry_t)) u_com (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr        (1'b0),
        .push       (commit && !merge_hit),
        .push_data  (spec_head),
        .pop        (com_pop),
        .merge      (commit && merge_hit),
        .merge_data (merged),
        .cnt        (com_cnt),
        .head_idx   (com_head_idx),
        .entries    (com_entries),
        .vld        (com_vld)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= SMQ_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        mem_req_o = 1'b0;
        case (state_q)
            SMQ_IDLE:     if (com_cnt != '0) state_d = SMQ_REQ;
            SMQ_REQ: begin
                mem_req_o = 1'b1;
                if (mem_gnt_i) state_d = SMQ_WAIT_ACK;
            end
            SMQ_WAIT_ACK: if (mem_ack_i) state_d = SMQ_IDLE;
            default:      state_d = SMQ_IDLE;
        endcase
    end

    assign mem_addr_o = com_head.paddr[PADDR_W-1:0];
    assign mem_data_o = com_head.data[DATA_W-1:0];
    assign mem_be_o   = com_head.be[BE_W-1:0];

    assign pg = SMQ_PADDR_W'(page_offset_i);

    always_comb begin
        page_offset_matches_o = valid_i && smq_word_match(pg, SMQ_PADDR_W'(paddr_i[11:0]), DATA_W);
        for (int i = 0; i < DEPTH; i++) begin
            if (spec_vld[i] && smq_word_match(pg, SMQ_PADDR_W'(spec_entries[i].paddr[11:0]), DATA_W))
                page_offset_matches_o = 1'b1;
            if (com_vld[i] && smq_word_match(pg, SMQ_PADDR_W'(com_entries[i].paddr[11:0]), DATA_W))
                page_offset_matches_o = 1'b1;
        end
    end

    assign no_st_pending_o = com_cnt == '0 && !in_flight;
    assign empty_o         = no_st_pending_o && spec_cnt == '0;

    commit_legal: assert property (@(posedge clk_i) disable iff (!rst_ni) commit_i |-> commit_ready_o);

endmodule

// File: tb/tb_store_merge_queue.sv
// Scoreboard bench: expected dcache writes are queued at commit and checked at grant.
module tb_store_merge_queue;

    logic        clk_i = 1'b0, rst_ni = 1'b0, flush_i = 1'b0, valid_i = 1'b0, commit_i = 1'b0;
    logic        mem_gnt_i = 1'b0, mem_ack_i = 1'b0;
    logic [55:0] paddr_i = '0;
    logic [63:0] data_i = '0;
    logic [7:0]  be_i = '0;
    logic [11:0] page_offset_i = '0;
    logic        ready_o, commit_ready_o, page_offset_matches_o, no_st_pending_o, empty_o, mem_req_o;
    logic [55:0] mem_addr_o;
    logic [63:0] mem_data_o;
    logic [7:0]  mem_be_o;

    store_merge_queue #(.DEPTH(4), .DATA_W(64), .PADDR_W(56), .MERGE_EN(1'b1)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
        .paddr_i(paddr_i), .data_i(data_i), .be_i(be_i), .commit_i(commit_i),
        .commit_ready_o(commit_ready_o), .page_offset_i(page_offset_i),
        .page_offset_matches_o(page_offset_matches_o), .no_st_pending_o(no_st_pending_o),
        .empty_o(empty_o), .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_be_o(mem_be_o), .mem_ack_i(mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [55:0] addr;
        logic [63:0] data;
        logic [7:0]  be;
    } wr_t;

    wr_t exp_q[$];
    wr_t spec_q[$];
    int  vecs = 0;
    int  errs = 0;
    bit  gnt_en = 1'b1, ack_en = 1'b1, waiting = 1'b0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    // dcache model: grant when enabled, ack at the earliest one cycle later when enabled
    initial forever begin
        @(posedge clk_i);
        #1;
        mem_gnt_i = 1'b0;
        mem_ack_i = 1'b0;
        if (!rst_ni) begin
            waiting = 1'b0;
        end else if (waiting) begin
            chk("req_while_outstanding", mem_req_o, 0);
            if (ack_en) begin
                mem_ack_i = 1'b1;
                waiting   = 1'b0;
            end
        end else if (mem_req_o && gnt_en) begin
            mem_gnt_i = 1'b1;
            waiting   = 1'b1;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", mem_addr_o, e.addr);
                chk("wr_data", mem_data_o, e.data);
                chk("wr_be", mem_be_o, e.be);
            end
        end
    end

    task automatic do_push(input logic [55:0] a, input logic [63:0] d, input logic [7:0] b);
        wr_t e;
        paddr_i = a; data_i = d; be_i = b; valid_i = 1'b1;
        #1;
        chk("push_ready", ready_o, 1);
        if (ready_o) begin
            e.addr = a; e.data = d; e.be = b;
            spec_q.push_back(e);
        end
        tick();
        valid_i = 1'b0;
    endtask

    task automatic do_commit(input bit with_flush);
        wr_t e, t;
        #1;
        chk("commit_ready", commit_ready_o, 1);
        if (!commit_ready_o || spec_q.size() == 0) return;
        e = spec_q.pop_front();
        if (exp_q.size() != 0 && exp_q[exp_q.size()-1].addr[55:3] == e.addr[55:3]) begin
            t = exp_q[exp_q.size()-1];
            for (int b = 0; b < 8; b++) if (e.be[b]) t.data[8*b +: 8] = e.data[8*b +: 8];
            t.be = t.be | e.be;
            exp_q[exp_q.size()-1] = t;
        end else begin
            exp_q.push_back(e);
        end
        commit_i = 1'b1;
        flush_i  = with_flush;
        tick();
        commit_i = 1'b0;
        flush_i  = 1'b0;
        if (with_flush) spec_q.delete();
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (empty_o && exp_q.size() == 0) break;
            tick();
        end
        chk({tag, "_empty"}, empty_o, 1);
        chk({tag, "_writes_left"}, exp_q.size(), 0);
    endtask

    task automatic wait_grant(input string tag);
        for (int i = 0; i < 50 && !waiting; i++) tick();
        chk({tag, "_granted"}, waiting, 1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, ready_o, 1);
        chk({tag, "_commit_ready"}, commit_ready_o, 0);
        chk({tag, "_mem_req"}, mem_req_o, 0);
        chk({tag, "_empty"}, empty_o, 1);
        chk({tag, "_no_st_pending"}, no_st_pending_o, 1);
        chk({tag, "_page_match"}, page_offset_matches_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        chk_reset("rst0");
        rst_ni = 1'b1;
        tick();

        // three distinct words drain in order
        do_push(56'h1000, 64'hA1A1_A1A1_0000_0001, 8'hFF);
        do_push(56'h1008, 64'hB2B2_B2B2_0000_0002, 8'hFF);
        do_push(56'h1010, 64'hC3C3_C3C3_0000_0003, 8'hFF);
        chk("s1_not_empty", empty_o, 0);
        do_commit(0);
        do_commit(0);
        do_commit(0);
        wait_drain("s1");

        // two halves of one word merge while the write is held off
        gnt_en = 1'b0;
        do_push(56'h2000, 64'h0000_0000_1111_1111, 8'h0F);
        do_push(56'h2000, 64'h2222_2222_0000_0000, 8'hF0);
        do_commit(0);
        do_commit(0);
        tick();
        chk("s2_req", mem_req_o, 1);
        chk("s2_data", mem_data_o, 64'h2222_2222_1111_1111);
        chk("s2_be", mem_be_o, 8'hFF);
        gnt_en = 1'b1;
        wait_drain("s2");

        // first half already granted: no merge, two writes
        ack_en = 1'b0;
        do_push(56'h2000, 64'h0000_0000_1111_1111, 8'h0F);
        do_push(56'h2000, 64'h2222_2222_0000_0000, 8'hF0);
        do_commit(0);
        wait_grant("s3");
        do_commit(0);
        ack_en = 1'b1;
        wait_drain("s3");

        // full speculative queue, flush together with commit
        gnt_en = 1'b0;
        for (int i = 0; i < 4; i++) do_push(56'h5000 + 56'(8*i), 64'h5000 + 64'(i), 8'hFF);
        #1;
        chk("s4_full_ready", ready_o, 0);
        do_commit(1);
        chk("s4_ready_after_flush", ready_o, 1);
        chk("s4_commit_ready_after_flush", commit_ready_o, 0);
        chk("s4_committed_pending", no_st_pending_o, 0);
        gnt_en = 1'b1;
        wait_drain("s4");

        // committed queue full: commit refused in the ack cycle, taken the next one
        gnt_en = 1'b0;
        ack_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_push(56'h6000 + 56'(8*i), 64'h6000 + 64'(i), 8'hFF);
            do_commit(0);
        end
        do_push(56'h6100, 64'h6100, 8'hFF);
        #1;
        chk("s5_com_full", commit_ready_o, 0);
        gnt_en = 1'b1;
        wait_grant("s5");
        gnt_en = 1'b0;
        chk("s5_full_in_flight", commit_ready_o, 0);
        ack_en = 1'b1;
        tick();
        ack_en = 1'b0;
        chk("s5_ack_seen", mem_ack_i, 1);
        chk("s5_refused_in_ack_cycle", commit_ready_o, 0);
        tick();
        chk("s5_accept_after_ack", commit_ready_o, 1);
        do_commit(0);
        gnt_en = 1'b1;
        ack_en = 1'b1;
        wait_drain("s5");

        // page-offset hazard, then reset while a write is outstanding
        gnt_en = 1'b0;
        do_push(56'h3A48, 64'h3A48, 8'hFF);
        page_offset_i = 12'hA4C;
        #1;
        chk("s6_spec_hit", page_offset_matches_o, 1);
        page_offset_i = 12'hA50;
        #1;
        chk("s6_spec_miss", page_offset_matches_o, 0);
        paddr_i = 56'h7A50;
        valid_i = 1'b1;
        #1;
        chk("s6_incoming_hit", page_offset_matches_o, 1);
        valid_i = 1'b0;
        page_offset_i = 12'hA4C;
        ack_en = 1'b0;
        do_commit(0);
        gnt_en = 1'b1;
        wait_grant("s6");
        #1;
        chk("s6_in_flight_hit", page_offset_matches_o, 1);
        chk("s6_pending", no_st_pending_o, 0);
        rst_ni = 1'b0;
        tick();
        chk_reset("rst_wait_ack");
        rst_ni = 1'b1;
        exp_q.delete();
        spec_q.delete();
        ack_en = 1'b1;
        tick();
        tick();
        chk("post_reset_idle_req", mem_req_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
